// File: rtl/key_gen_pkg.sv
// -----------------------------------------------------------------------------
// key_gen_pkg
// Shared constants for the key stimulus generators: FSM state encoding,
// LFSR feedback tap mask and the default LFSR seed.
// -----------------------------------------------------------------------------
package key_gen_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] PRESS_BNC = 2'd1;
    localparam logic [1:0] HOLD      = 2'd2;
    localparam logic [1:0] REL_BNC   = 2'd3;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;

    // Default seed; any nonzero value keeps the LFSR out of the lock-up state
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Fibonacci LFSR. The seed is loaded while rst_n is low
// (synchronous); afterwards the register advances on every clock.
// Ports:
//   clk   in   system clock
//   rst_n in   synchronous active-low reset, loads seed
//   seed  in   16-bit reset value, must be nonzero
//   o_q   out  current LFSR state
// -----------------------------------------------------------------------------
module lfsr16
    import key_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] o_q
);

    logic [15:0] q_q;
    logic [15:0] q_d;
    logic        fb;

    always_comb begin
        fb  = ^(q_q & LFSR_TAP_MASK);
        q_d = {q_q[14:0], fb};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign o_q = q_q;

endmodule

// File: rtl/key_bounce_gen.sv
// -----------------------------------------------------------------------------
// key_bounce_gen
// Drives a raw active-low push-button line. Each accepted start produces one
// press / hold / release event, optionally with LFSR-driven contact bounce on
// both edges.
// Ports:
//   clk            in   system clock
//   rst_n          in   synchronous active-low reset
//   i_start        in   one-cycle event request, honoured only when idle
//   i_bounce_en    in   1 = bounce on both edges (latched with i_start)
//   i_hold_cycles  in   stable-low length, latched with i_start, 0 acts as 1
//   i_abort        in   terminate the current event on the next edge
//   o_Key          out  raw key line, 1 = released, 0 = pressed
//   o_busy         out  high while an event is in progress
//   o_done         out  one-cycle pulse on normal completion
//   o_press_cnt    out  completed event count, wraps at 16 bits
// Handshake: i_start is a request that is consumed only on an edge where the
// FSM is IDLE and i_abort is low; otherwise it is dropped (never queued).
// -----------------------------------------------------------------------------
module key_bounce_gen
    import key_gen_pkg::*;
#(
    parameter int          BOUNCE_CYCLES = 100000,
    parameter int          BNC_W         = 17,
    parameter int          SEG_W         = 12,
    parameter int          HOLD_W        = 24,
    parameter logic [15:0] LFSR_SEED     = LFSR_SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_bounce_en,
    input  logic [HOLD_W-1:0] i_hold_cycles,
    input  logic              i_abort,
    output logic              o_Key,
    output logic              o_busy,
    output logic              o_done,
    output logic [15:0]       o_press_cnt
);

    localparam logic [BNC_W-1:0] WIN_LOAD = BNC_W'(BOUNCE_CYCLES - 1);

    logic [1:0]        state_q,  state_d;
    logic              key_q,    key_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic [15:0]       cnt_q,    cnt_d;
    logic [BNC_W-1:0]  win_q,    win_d;
    logic [SEG_W-1:0]  seg_q,    seg_d;
    logic [HOLD_W-1:0] hold_q,   hold_d;
    logic              bnc_en_q, bnc_en_d;

    logic [15:0]       lfsr_val;
    logic [SEG_W-1:0]  seg_seed;
    logic              unused_lfsr_bits;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .o_q   (lfsr_val)
    );

    // Forcing bit 0 guarantees every bounce segment is at least one clock
    assign seg_seed         = lfsr_val[SEG_W-1:0] | SEG_W'(1);
    assign unused_lfsr_bits = ^lfsr_val;

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        win_d    = win_q;
        seg_d    = seg_q;
        hold_d   = hold_q;
        bnc_en_d = bnc_en_q;

        case (state_q)
            IDLE: begin
                if (i_start && !i_abort) begin
                    key_d    = 1'b0;
                    bnc_en_d = i_bounce_en;
                    // Hold counter counts down to 0, so load H-1 with H = max(i,1)
                    hold_d   = (i_hold_cycles == '0) ? '0 : i_hold_cycles - HOLD_W'(1);
                    if (i_bounce_en) begin
                        state_d = PRESS_BNC;
                        win_d   = WIN_LOAD;
                        seg_d   = seg_seed;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end

            PRESS_BNC, REL_BNC: begin
                if (win_q == '0) begin
                    // Window end: the final level wins over any pending toggle
                    key_d = (state_q == REL_BNC);
                    if (state_q == PRESS_BNC) begin
                        state_d = HOLD;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        cnt_d   = cnt_q + 16'd1;
                    end
                end else begin
                    win_d = win_q - BNC_W'(1);
                    if (seg_q == '0) begin
                        key_d = ~key_q;
                        seg_d = seg_seed;
                    end else begin
                        seg_d = seg_q - SEG_W'(1);
                    end
                end
            end

            HOLD: begin
                if (hold_q == '0) begin
                    key_d = 1'b1;
                    if (bnc_en_q) begin
                        state_d = REL_BNC;
                        win_d   = WIN_LOAD;
                        seg_d   = seg_seed;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        cnt_d   = cnt_q + 16'd1;
                    end
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                key_d   = 1'b1;
            end
        endcase

        // Abort overrides everything above; in IDLE it also blocks a start
        if (i_abort && (state_q != IDLE)) begin
            state_d = IDLE;
            key_d   = 1'b1;
            done_d  = 1'b0;
            cnt_d   = cnt_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            key_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            win_q    <= '0;
            seg_q    <= '0;
            hold_q   <= '0;
            bnc_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            seg_q    <= seg_d;
            hold_q   <= hold_d;
            bnc_en_q <= bnc_en_d;
        end
    end

    assign o_Key       = key_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_press_cnt = cnt_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// -----------------------------------------------------------------------------
// tb_key_bounce_gen
// Directed bench for key_bounce_gen. Stimulus tasks push the expected
// completion (cycle, count) of every event into exp_q; a monitor pops and
// compares on every o_done pulse. Level checks on o_Key/o_busy are made by
// the stimulus sequence one time unit after the active edge.
// -----------------------------------------------------------------------------
module tb_key_bounce_gen;

    localparam int BOUNCE_CYCLES = 16;
    localparam int BNC_W         = 5;
    localparam int SEG_W         = 3;
    localparam int HOLD_W        = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_start;
    logic              i_bounce_en;
    logic [HOLD_W-1:0] i_hold_cycles;
    logic              i_abort;
    logic              o_Key;
    logic              o_busy;
    logic              o_done;
    logic [15:0]       o_press_cnt;

    key_bounce_gen #(
        .BOUNCE_CYCLES (BOUNCE_CYCLES),
        .BNC_W         (BNC_W),
        .SEG_W         (SEG_W),
        .HOLD_W        (HOLD_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_bounce_en   (i_bounce_en),
        .i_hold_cycles (i_hold_cycles),
        .i_abort       (i_abort),
        .o_Key         (o_Key),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_press_cnt   (o_press_cnt)
    );

    // ---------------- clock / cycle counter ----------------
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_cnt  = 16'd0;
    logic [47:0] exp_q[$];   // {expected count, expected done cycle}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge; returns the cycle index of E0
    task automatic start_event(input logic bnc, input logic [HOLD_W-1:0] hold, output int e0);
        i_bounce_en   = bnc;
        i_hold_cycles = hold;
        i_start       = 1'b1;
        step(1);
        i_start = 1'b0;
        e0      = cyc;
    endtask

    task automatic expect_done(input int done_cyc);
        exp_cnt = exp_cnt + 16'd1;
        exp_q.push_back({exp_cnt, 32'(done_cyc)});
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && o_done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got o_done=1 expected no completion (cycle %0d)", cyc);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                check("done_cycle", 32'(cyc), e[31:0]);
                check("done_cnt", {16'd0, o_press_cnt}, {16'd0, e[47:32]});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int   e0;
        logic saw_hi;
        logic saw_lo;
        logic busy_ok;

        rst_n         = 1'b0;
        i_start       = 1'b0;
        i_bounce_en   = 1'b0;
        i_hold_cycles = '0;
        i_abort       = 1'b0;
        step(3);
        check("rst_key", o_Key, 1);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_cnt", o_press_cnt, 0);
        rst_n = 1'b1;

        // 1. idle after reset
        for (int k = 0; k < 20; k++) begin
            step(1);
            check("idle_state", {o_Key, o_busy, o_done, o_press_cnt}, {1'b1, 1'b0, 1'b0, 16'd0});
        end

        // 2. clean edges, H=5
        start_event(1'b0, 8'd5, e0);
        expect_done(e0 + 5);
        for (int k = 0; k < 5; k++) begin
            check("t2_key_low", o_Key, 0);
            check("t2_busy", o_busy, 1);
            step(1);
        end
        check("t2_key_rel", o_Key, 1);
        check("t2_busy_end", o_busy, 0);
        check("t2_cnt", o_press_cnt, 1);
        step(2);

        // 3. bounce on, H=10
        start_event(1'b1, 8'd10, e0);
        expect_done(e0 + 42);
        check("t3_key_e0", o_Key, 0);
        saw_hi  = 1'b0;
        saw_lo  = 1'b0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 42; k++) begin
            step(1);
            if (k < 42 && !o_busy) busy_ok = 1'b0;
            if (k <= 15 && o_Key) saw_hi = 1'b1;
            if (k >= 16 && k <= 25) check("t3_hold_low", o_Key, 0);
            if (k == 26) check("t3_rel_start", o_Key, 1);
            if (k >= 27 && k <= 41 && !o_Key) saw_lo = 1'b1;
            if (k == 42) begin
                check("t3_key_end", o_Key, 1);
                check("t3_busy_end", o_busy, 0);
            end
        end
        check("t3_press_bounce", saw_hi, 1);
        check("t3_rel_bounce", saw_lo, 1);
        check("t3_busy_thru", busy_ok, 1);
        step(2);

        // 4. H=0 acts as one clock
        start_event(1'b0, 8'd0, e0);
        expect_done(e0 + 1);
        check("t4_key_low", o_Key, 0);
        step(1);
        check("t4_key_rel", o_Key, 1);
        check("t4_busy_end", o_busy, 0);
        step(2);

        // 5. extra starts while busy are dropped
        start_event(1'b0, 8'd8, e0);
        expect_done(e0 + 8);
        step(1);
        i_start = 1'b1;
        step(2);
        i_start = 1'b0;
        step(4);
        check("t5_key_low", o_Key, 0);
        step(1);
        check("t5_key_rel", o_Key, 1);
        check("t5_busy_end", o_busy, 0);
        step(12);
        check("t5_stay_idle", o_busy, 0);
        check("t5_cnt", o_press_cnt, 32'(exp_cnt));

        // abort together with start in IDLE: nothing starts
        i_start = 1'b1;
        i_abort = 1'b1;
        step(1);
        i_start = 1'b0;
        i_abort = 1'b0;
        check("abort_idle_busy", o_busy, 0);
        check("abort_idle_key", o_Key, 1);
        step(2);

        // 6a. abort mid-HOLD
        start_event(1'b1, 8'd10, e0);
        step(19);
        i_abort = 1'b1;
        step(1);
        i_abort = 1'b0;
        check("t6_abort_key", o_Key, 1);
        check("t6_abort_busy", o_busy, 0);
        check("t6_abort_cnt", o_press_cnt, 32'(exp_cnt));
        step(5);

        // 6b. reset mid-PRESS_BNC
        start_event(1'b1, 8'd10, e0);
        step(5);
        check("t6_pre_rst_busy", o_busy, 1);
        rst_n = 1'b0;
        step(1);
        exp_cnt = 16'd0;
        check("t6_rst_key", o_Key, 1);
        check("t6_rst_cnt", o_press_cnt, 0);
        check("t6_rst_busy", o_busy, 0);
        rst_n = 1'b1;
        step(5);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
